// File: rtl/ser_shift_master.sv
`default_nettype none
// ============================================================================
//  Module   : ser_shift_master
//  Purpose  : Serial shifter for latch-enable and chip-select style serial
//             ports. One load strobe sends a frame of up to DATA_W bits,
//             MSB first, with programmable timing. Optional serial readback
//             is captured into rd_data.
//  Revision : 1.0  initial release
//
//  Build option:
//    SER_READBACK_EN  defined   -> readback shift register present
//                     undefined -> ser_din ignored, rd_data tied to 0
//
//  Ports:
//    cpu_clk        in   sole clock
//    rst            in   synchronous active-high reset
//    wr_stb         in   single-cycle load strobe
//    wr_data        in   frame payload, bits [n-1:0] are sent
//    wr_len         in   bit count n (0 or >DATA_W selects DATA_W)
//    le_pulse_mode  in   0 = chip-select framing, 1 = latch-pulse framing
//    ser_din        in   serial readback input
//    busy           out  frame in progress
//    done           out  one-cycle pulse at frame completion
//    err            out  sticky: load strobe seen while busy
//    ser_le         out  frame / latch strobe, active-high
//    ser_clk        out  serial clock, idle low
//    ser_dat        out  serial data, MSB first
//    rd_data        out  captured readback, right-justified
// ============================================================================
module ser_shift_master #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = $clog2(DATA_W) + 1
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic              wr_stb,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic              le_pulse_mode,
    input  logic              ser_din,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ser_le,
    output logic              ser_clk,
    output logic              ser_dat,
    output logic [DATA_W-1:0] rd_data
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div, div_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [DATA_W-1:0] data, data_nxt;
    logic              mode, mode_nxt;
    logic              err_nxt;
    logic              busy_nxt, done_nxt, le_nxt, clk_nxt, dat_nxt;
    logic [IDX_W-1:0]  first_idx;
    logic              div_last;

    assign div_last = (div == DIV_W'(CLK_DIV - 1));

    // Index of the first (most significant) bit to send.
    always_comb begin
        first_idx = IDX_W'(DATA_W - 1);
        if (wr_len != '0 && wr_len <= LEN_W'(DATA_W)) begin
            first_idx = IDX_W'(wr_len - 1'b1);
        end
    end

    // Next-state logic. The serial outputs are decoded from the NEXT state so
    // that every output is a plain register aligned with its state.
    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        idx_nxt   = idx;
        data_nxt  = data;
        mode_nxt  = mode;
        err_nxt   = err;

        if (state != S_IDLE) begin
            div_nxt = div_last ? '0 : div + 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (wr_stb) begin
                    state_nxt = S_SETUP;
                    div_nxt   = '0;
                    data_nxt  = wr_data;
                    idx_nxt   = first_idx;
                    mode_nxt  = le_pulse_mode;
                    err_nxt   = 1'b0;
                end
            end
            S_SETUP: if (div_last) state_nxt = S_LOW;
            S_LOW:   if (div_last) state_nxt = S_HIGH;
            S_HIGH: begin
                if (div_last) begin
                    if (idx != '0) begin
                        idx_nxt   = idx - 1'b1;
                        state_nxt = S_LOW;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD:  if (div_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // A strobe during a frame is dropped; only the sticky flag records it.
        if (wr_stb && state != S_IDLE) begin
            err_nxt = 1'b1;
        end

        busy_nxt = (state_nxt != S_IDLE);
        clk_nxt  = (state_nxt == S_HIGH);
        le_nxt   = (state_nxt == S_HOLD) || (busy_nxt && !mode_nxt);
        dat_nxt  = 1'b0;
        if (state_nxt == S_SETUP || state_nxt == S_LOW || state_nxt == S_HIGH) begin
            dat_nxt = data_nxt[idx_nxt];
        end
        done_nxt = (state == S_HOLD) && (state_nxt == S_IDLE);
    end

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state   <= S_IDLE;
            div     <= '0;
            idx     <= '0;
            data    <= '0;
            mode    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ser_le  <= 1'b0;
            ser_clk <= 1'b0;
            ser_dat <= 1'b0;
        end else begin
            state   <= state_nxt;
            div     <= div_nxt;
            idx     <= idx_nxt;
            data    <= data_nxt;
            mode    <= mode_nxt;
            err     <= err_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            ser_le  <= le_nxt;
            ser_clk <= clk_nxt;
            ser_dat <= dat_nxt;
        end
    end

`ifdef SER_READBACK_EN
    logic [DATA_W-1:0] cap;
    logic [DATA_W-1:0] rd_q;

    // Capture register is cleared at frame accept, so after n samples the
    // bits above n-1 are already zero and the result is right-justified.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            cap  <= '0;
            rd_q <= '0;
        end else begin
            if (state == S_IDLE && wr_stb) begin
                cap <= '0;
            end else if (state == S_HIGH && div_last) begin
                cap <= (cap << 1) | DATA_W'(ser_din);
            end
            if (done_nxt) begin
                rd_q <= cap;
            end
        end
    end

    assign rd_data = rd_q;
`else
    logic unused_din;
    assign unused_din = ser_din;
    assign rd_data    = '0;
`endif

endmodule
`default_nettype wire
